// File: rtl/l2_port_arbiter_if.sv
// Bundle of requester-side, L2-side and status signals for l2_port_arbiter.
// The arbiter connects through the slave modport; the environment (requesters + L2) uses master.
interface l2_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_error;

  logic                  mem_request;
  logic                  mem_write_enable;
  logic [31:0]           mem_address;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_response_data;
  logic                  mem_ready;

  logic                  busy;
  logic [ID_W-1:0]       grant_id;
  logic [7:0]            timeout_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_response_data, mem_ready,
    output resp_ready, resp_data, resp_error,
    output mem_request, mem_write_enable, mem_address, mem_write_data,
    output busy, grant_id, timeout_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_response_data, mem_ready,
    input  resp_ready, resp_data, resp_error,
    input  mem_request, mem_write_enable, mem_address, mem_write_data,
    input  busy, grant_id, timeout_count
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port among NUM_REQ L1 requesters.
// Grant is held until mem_ready or the watchdog fires; every output is registered.
module l2_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic              clk,
  input logic              reset,
  l2_port_arbiter_if.slave bus
);

  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]   ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WD_W-1:0]    r_wd_cnt;
  logic [ID_W-1:0]    r_grant_id;
  logic [NUM_REQ-1:0] r_resp_ready;
  logic [31:0]        r_resp_data;
  logic               r_resp_error;
  logic               r_mem_request;
  logic               r_mem_write_enable;
  logic [31:0]        r_mem_address;
  logic [31:0]        r_mem_write_data;
  logic               r_busy;
  logic [7:0]         r_timeout_count;

  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [ID_W-1:0]    w_next_ptr;

  // Scan downward so the last hit written is the one closest to r_rr_ptr.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin : rr_select
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        w_any = 1'b1;
        w_sel = ID_W'(idx);
      end
    end
  end

  assign w_sel_addr  = bus.req_addr[32*w_sel +: 32];
  assign w_sel_wdata = bus.req_wdata[32*w_sel +: 32];
  assign w_next_ptr  = (r_grant_id == ID_LAST) ? '0 : r_grant_id + ID_W'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_rr_ptr           <= '0;
      r_wd_cnt           <= '0;
      r_grant_id         <= '0;
      r_resp_ready       <= '0;
      r_resp_data        <= '0;
      r_resp_error       <= 1'b0;
      r_mem_request      <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write_data   <= '0;
      r_busy             <= 1'b0;
      r_timeout_count    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id         <= w_sel;
            r_mem_write_enable <= bus.req_we[w_sel];
            r_mem_address      <= w_sel_addr;
            r_mem_write_data   <= w_sel_wdata;
            r_mem_request      <= 1'b1;
            r_busy             <= 1'b1;
            r_wd_cnt           <= '0;
            r_state            <= S_BUSY;
          end
        end

        // mem_ready wins over a watchdog expiry in the same cycle.
        S_BUSY: begin
          if (bus.mem_ready) begin
            r_resp_data        <= bus.mem_response_data;
            r_resp_ready       <= NUM_REQ'(1) << r_grant_id;
            r_resp_error       <= 1'b0;
            r_mem_request      <= 1'b0;
            r_mem_write_enable <= 1'b0;
            r_rr_ptr           <= w_next_ptr;
            r_state            <= S_DONE;
          end else if (r_wd_cnt == WD_LAST) begin
            r_resp_data   <= '0;
            r_resp_ready  <= NUM_REQ'(1) << r_grant_id;
            r_resp_error  <= 1'b1;
            r_mem_request <= 1'b0;
            if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= S_DONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end

        // One-cycle response slot; requests are not sampled here.
        S_DONE: begin
          r_resp_ready <= '0;
          r_resp_error <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_ready       = r_resp_ready;
  assign bus.resp_data        = r_resp_data;
  assign bus.resp_error       = r_resp_error;
  assign bus.mem_request      = r_mem_request;
  assign bus.mem_write_enable = r_mem_write_enable;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_write_data   = r_mem_write_data;
  assign bus.busy             = r_busy;
  assign bus.grant_id         = r_grant_id;
  assign bus.timeout_count    = r_timeout_count;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: two requesters, 8-cycle watchdog.
// Inputs change 1ns after posedge and outputs are sampled there too.
module tb_l2_port_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  l2_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  l2_port_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int cycles);
    cycles = 0;
    while (!bus.mem_request && cycles < 50) begin
      tick();
      cycles++;
    end
    check({tag, "_granted"}, 32'(bus.mem_request), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic complete(input logic [31:0] rdata);
    bus.mem_response_data = rdata;
    bus.mem_ready         = 1'b1;
    tick();
    bus.mem_ready         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int gap;
    reset                 = 1'b1;
    bus.req_valid         = '0;
    bus.req_we            = '0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.mem_response_data = '0;
    bus.mem_ready         = 1'b0;
    repeat (3) tick();

    check("rst_mem_request", 32'(bus.mem_request), 32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_resp_ready",  32'(bus.resp_ready),  32'd0);
    check("rst_grant_id",    32'(bus.grant_id),    32'd0);
    check("rst_mem_address", bus.mem_address,      32'd0);
    check("rst_timeouts",    32'(bus.timeout_count), 32'd0);
    reset = 1'b0;
    tick();

    // mem_ready while idle must do nothing
    bus.mem_response_data = 32'h1111_1111;
    bus.mem_ready         = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("idle_ready_resp", 32'({bus.resp_ready, bus.busy}), 32'd0);
    check("idle_ready_data", bus.resp_data, 32'd0);

    // Single read, mem_ready in the third BUSY cycle
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h0, 32'h0000_1000};
    bus.req_valid = 2'b01;
    tick();
    check("rd_mem_request", 32'(bus.mem_request),      32'd1);
    check("rd_mem_address", bus.mem_address,           32'h0000_1000);
    check("rd_mem_we",      32'(bus.mem_write_enable), 32'd0);
    check("rd_busy",        32'(bus.busy),             32'd1);
    check("rd_grant_id",    32'(bus.grant_id),         32'd0);
    tick();
    tick();
    complete(32'hDEAD_BEEF);
    check("rd_resp_ready",  32'(bus.resp_ready),  32'h1);
    check("rd_resp_data",   bus.resp_data,        32'hDEAD_BEEF);
    check("rd_resp_error",  32'(bus.resp_error),  32'd0);
    check("rd_req_dropped", 32'(bus.mem_request), 32'd0);
    bus.req_valid = 2'b00;
    tick();
    check("rd_pulse_one_cycle", 32'(bus.resp_ready), 32'd0);
    check("rd_busy_clear",      32'(bus.busy),       32'd0);

    // Simultaneous requests after reset
    apply_reset();
    bus.req_addr  = {32'h0000_0B00, 32'h0000_0A00};
    bus.req_valid = 2'b11;
    tick();
    check("sim_first_grant", 32'(bus.grant_id), 32'd0);
    check("sim_first_addr",  bus.mem_address,   32'h0000_0A00);
    complete(32'h0000_00A0);
    check("sim_first_resp", 32'(bus.resp_ready), 32'h1);
    bus.req_valid = 2'b10;
    tick();
    check("sim_idle_gap", 32'(bus.mem_request), 32'd0);
    tick();
    check("sim_second_grant", 32'(bus.grant_id), 32'd1);
    check("sim_second_addr",  bus.mem_address,   32'h0000_0B00);
    bus.req_valid = 2'b11;
    tick();
    tick();
    check("sim_hold_grant", 32'(bus.grant_id), 32'd1);
    check("sim_hold_addr",  bus.mem_address,   32'h0000_0B00);
    complete(32'h0000_00B0);
    check("sim_second_resp", 32'(bus.resp_ready), 32'h2);
    bus.req_valid = 2'b01;
    wait_grant("sim_third", gap);
    check("sim_min_gap",     32'(gap),          32'd2);
    check("sim_third_grant", 32'(bus.grant_id), 32'd0);
    complete(32'h0000_00C0);
    check("sim_third_resp", 32'(bus.resp_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();

    // Fairness with both requests held
    apply_reset();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_grant("fair", gap);
      check("fair_grant_id", 32'(bus.grant_id), 32'(i % 2));
      if (i > 0) check("fair_gap", 32'(gap), 32'd2);
      complete(32'(i));
      check("fair_resp_ready", 32'(bus.resp_ready), 32'(1 << (i % 2)));
    end
    bus.req_valid = 2'b00;
    tick();

    // Write passthrough from requester 1, inputs disturbed mid-BUSY
    bus.req_we    = 2'b10;
    bus.req_addr  = {32'h0000_2004, 32'h0};
    bus.req_wdata = {32'h1234_5678, 32'h0};
    bus.req_valid = 2'b10;
    wait_grant("wr", gap);
    check("wr_grant_id", 32'(bus.grant_id),         32'd1);
    check("wr_mem_we",   32'(bus.mem_write_enable), 32'd1);
    check("wr_addr",     bus.mem_address,           32'h0000_2004);
    check("wr_wdata",    bus.mem_write_data,        32'h1234_5678);
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'hFFFF_0000, 32'h0};
    bus.req_wdata = {32'h0, 32'h0};
    tick();
    tick();
    check("wr_stable_we",    32'(bus.mem_write_enable), 32'd1);
    check("wr_stable_addr",  bus.mem_address,           32'h0000_2004);
    check("wr_stable_wdata", bus.mem_write_data,        32'h1234_5678);
    complete(32'hA5A5_A5A5);
    check("wr_resp_ready", 32'(bus.resp_ready),       32'h2);
    check("wr_resp_data",  bus.resp_data,             32'hA5A5_A5A5);
    check("wr_we_cleared", 32'(bus.mem_write_enable), 32'd0);
    bus.req_valid = 2'b00;
    tick();

    // Watchdog: no mem_ready for 8 BUSY cycles
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h0, 32'h0000_3000};
    bus.req_valid = 2'b01;
    wait_grant("to", gap);
    repeat (TIMEOUT - 1) tick();
    check("to_still_busy", 32'(bus.mem_request), 32'd1);
    check("to_no_early",   32'(bus.resp_ready),  32'd0);
    tick();
    check("to_resp_ready",  32'(bus.resp_ready),    32'h1);
    check("to_resp_error",  32'(bus.resp_error),    32'd1);
    check("to_resp_data",   bus.resp_data,          32'd0);
    check("to_mem_request", 32'(bus.mem_request),   32'd0);
    check("to_count",       32'(bus.timeout_count), 32'd1);
    bus.req_valid = 2'b00;
    tick();
    check("to_error_clear", 32'(bus.resp_error), 32'd0);
    check("to_busy_clear",  32'(bus.busy),       32'd0);

    // mem_ready on the watchdog's final cycle completes normally
    bus.req_valid = 2'b01;
    wait_grant("tie", gap);
    repeat (TIMEOUT - 1) tick();
    complete(32'h0000_600D);
    check("tie_resp_ready", 32'(bus.resp_ready),    32'h1);
    check("tie_resp_error", 32'(bus.resp_error),    32'd0);
    check("tie_resp_data",  bus.resp_data,          32'h0000_600D);
    check("tie_count",      32'(bus.timeout_count), 32'd1);
    bus.req_valid = 2'b00;
    tick();

    // Reset two cycles into a transaction granted to requester 1
    bus.req_addr  = {32'h0000_5001, 32'h0000_5000};
    bus.req_valid = 2'b11;
    wait_grant("mid", gap);
    check("mid_grant_id", 32'(bus.grant_id), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_mem_request", 32'(bus.mem_request),   32'd0);
    check("mid_rst_busy",        32'(bus.busy),          32'd0);
    check("mid_rst_resp_ready",  32'(bus.resp_ready),    32'd0);
    check("mid_rst_grant_id",    32'(bus.grant_id),      32'd0);
    check("mid_rst_timeouts",    32'(bus.timeout_count), 32'd0);
    tick();
    reset = 1'b0;
    wait_grant("mid_restart", gap);
    check("mid_restart_grant", 32'(bus.grant_id), 32'd0);
    check("mid_restart_addr",  bus.mem_address,   32'h0000_5000);
    complete(32'h0000_0777);
    check("mid_restart_resp", 32'(bus.resp_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
